man_frame_tx: RTL and testbench
===============================

MAN_FRAME_TX -- requirements
Module: man_frame_tx

Interface
REQ-001 SHALL have parameter HALF_ETU, default 8, meaning clocks per half bit period; legal values are 2 to 64 and even.
REQ-002 SHALL have parameter DATA_W, default 8, meaning bits per data word, sent LSB first.
REQ-003 SHALL have parameter PARITY_EN, default 1; when 1, an odd-parity bit follows each word.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, at twice the subcarrier rate (fc/8).
REQ-005 SHALL have port in_rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port in_enable, input, 1 bit: synchronous enable; low aborts the frame.
REQ-007 SHALL have port in_data, input, DATA_W bits: the word offered for transmission.
REQ-008 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-009 SHALL have port in_last, input, 1 bit: the offered word is the final word of the frame.
REQ-010 SHALL have port out_ready, output, 1 bit: the holding register is empty.
REQ-011 SHALL have port out_data, output, 1 bit: registered, subcarrier-modulated Manchester stream.
REQ-012 SHALL have port out_busy, output, 1 bit: a frame is in progress.
REQ-013 SHALL have port out_done, output, 1 bit: one-cycle pulse when EOF completes.
REQ-014 SHALL have port out_err, output, 1 bit: one-cycle pulse on underrun or abort.

Function
REQ-015 A word SHALL be accepted on a clk edge where in_valid, out_ready and in_enable are all 1; in_last is captured with it; out_ready then falls on the next cycle.
REQ-016 The holding register SHALL be a single entry; it SHALL move into the shift register at each word boundary, freeing out_ready while the current word is still being sent.
REQ-017 The state machine SHALL have states IDLE, SOF, DATA, PARITY and EOF.
REQ-018 IDLE -> SOF SHALL occur on the cycle after the holding register becomes full.
REQ-019 SOF -> DATA SHALL occur after one bit period.
REQ-020 DATA SHALL last DATA_W bit periods, then go to PARITY if PARITY_EN is 1, otherwise to the word boundary.
REQ-021 At the word boundary, the block SHALL go to EOF if the last word was sent, load the next word into DATA if one is held, and otherwise treat the condition as an underrun.
REQ-022 EOF -> IDLE SHALL occur after one bit period, with out_done pulsed on the final cycle of EOF.
REQ-023 One bit period SHALL be 2*HALF_ETU clocks, timed by a half-bit counter of width clog2(HALF_ETU) that wraps from HALF_ETU-1 to 0.
REQ-024 Logic 1 and SOF SHALL be modulated in the first half and unmodulated in the second half.
REQ-025 Logic 0 SHALL be unmodulated in the first half and modulated in the second half.
REQ-026 EOF SHALL be unmodulated for both halves.
REQ-027 During a modulated half, out_data SHALL be 1 on the first cycle and then toggle every clock; during an unmodulated half, or outside a frame, out_data SHALL be 0.
REQ-028 The parity bit SHALL be the XOR of all DATA_W data bits, inverted, so that the total count of ones is odd.
REQ-029 On underrun, out_err SHALL pulse at the boundary and the frame SHALL end through a normal EOF, with out_done also pulsed.
REQ-030 When in_enable is low, the block SHALL go to IDLE on the next clock, clear the holding register, and drive out_data to 0; out_err SHALL pulse only if out_busy was 1.
REQ-031 While in_enable is low, out_ready SHALL be 0.
REQ-032 out_busy SHALL be 1 in every state except IDLE.
REQ-033 Holding a word offered while not ready SHALL cause no state change and no data loss.

Reset
REQ-034 While in_rst is 1, the block SHALL immediately force state IDLE, clear all counters and the holding register, and drive out_data, out_busy, out_done and out_err to 0 and out_ready to 1.
REQ-035 Assertion of in_rst in the middle of a frame SHALL discard the frame and pulse neither out_done nor out_err.
REQ-036 Deassertion of in_rst SHALL be synchronous to clk.

Structure
REQ-037 Package man_pkg SHALL hold the state enum, the default values of HALF_ETU and DATA_W, and the modulation-pattern constants.
REQ-038 Sub-module man_half_bit_gen SHALL contain the half-bit counter, the half flag, and the subcarrier toggle, and SHALL output the strobes half_end and bit_end.

Verification
REQ-039 With defaults, a single word 0xA5 with in_last=1 SHALL produce 11 bit periods (176 clocks) in the order SOF, 1,0,1,0,0,1,0,1, parity 1, EOF, with out_done pulsed at clock 176.
REQ-040 Two words 0x00 then 0xFF sent back-to-back, with the second offered during the first, SHALL give no gap, parity bits 1 and 1, and out_err 0.
REQ-041 A first word 0x3C with in_last=0 and no second word SHALL pulse out_err at the end of the first word's parity bit, followed by EOF and out_done.
REQ-042 Dropping in_enable in the middle of DATA (bit 4) SHALL return the block to IDLE one clock later, pulse out_err, and hold out_data at 0.
REQ-043 Asserting in_rst in the middle of SOF SHALL give out_data=0 immediately with no out_done; a new frame after release SHALL be sent correctly.
REQ-044 With HALF_ETU=4, DATA_W=4 and PARITY_EN=0, the word 0x9 SHALL produce 6 bit periods of 8 clocks each, and the check SHALL confirm the toggle pattern 1,0,1,0 in every modulated half.

Source files
------------

// File: rtl/man_pkg.sv
// Shared types and constants for the Manchester/subcarrier frame transmitter.
package man_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_DATA,
    ST_PARITY,
    ST_EOF
  } man_state_e;

  localparam int unsigned HALF_ETU_DEF = 8;
  localparam int unsigned DATA_W_DEF   = 8;

  // Bit [1] = first half modulated, bit [0] = second half modulated.
  localparam logic [1:0] PAT_ONE  = 2'b10;
  localparam logic [1:0] PAT_ZERO = 2'b01;
  localparam logic [1:0] PAT_NONE = 2'b00;

endpackage

// File: rtl/man_half_bit_gen.sv
// Half-bit timer: counts clocks within a half bit, tracks which half is active
// and produces the subcarrier toggle (1 on the first clock of every half).
module man_half_bit_gen #(
  parameter int unsigned HALF_ETU = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic half,
  output logic sub,
  output logic half_end,
  output logic bit_end
);

  localparam int unsigned CNT_W = (HALF_ETU > 1) ? $clog2(HALF_ETU) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             half_q, half_d;
  logic             sub_q, sub_d;

  always_comb begin
    half_end = (cnt_q == CNT_W'(HALF_ETU - 1));
    bit_end  = half_end & half_q;
    cnt_d    = cnt_q;
    half_d   = half_q;
    sub_d    = sub_q;
    if (!run) begin
      cnt_d  = '0;
      half_d = 1'b0;
      sub_d  = 1'b1;
    end else if (half_end) begin
      cnt_d  = '0;
      half_d = ~half_q;
      sub_d  = 1'b1;
    end else begin
      cnt_d  = cnt_q + 1'b1;
      sub_d  = ~sub_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      half_q <= 1'b0;
      sub_q  <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      half_q <= half_d;
      sub_q  <= sub_d;
    end
  end

  assign half = half_q;
  assign sub  = sub_q;

endmodule

// File: rtl/man_frame_tx.sv
// Frame transmitter: SOF, LSB-first data words with optional odd parity, EOF,
// Manchester coded onto a subcarrier. One-entry holding register feeds the shifter.
module man_frame_tx
  import man_pkg::*;
#(
  parameter int unsigned HALF_ETU  = HALF_ETU_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              in_rst,
  input  logic              in_enable,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              out_ready,
  output logic              out_data,
  output logic              out_busy,
  output logic              out_done,
  output logic              out_err
);

  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  man_state_e        state_q, state_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] hold_data_q, hold_data_d;
  logic              hold_last_q, hold_last_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic              cur_last_q, cur_last_d;
  logic              par_q, par_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              data_q, data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic       busy, run, accept, load, boundary;
  logic       half, sub, bit_end, half_end_unused;
  logic [1:0] pat;

  assign busy      = (state_q != ST_IDLE);
  assign run       = busy & in_enable;
  assign accept    = in_valid & in_enable & ~hold_full_q;
  assign out_ready = in_rst | (~hold_full_q & in_enable);

  man_half_bit_gen #(
    .HALF_ETU(HALF_ETU)
  ) u_half_bit_gen (
    .clk     (clk),
    .rst     (in_rst),
    .run     (run),
    .half    (half),
    .sub     (sub),
    .half_end(half_end_unused),
    .bit_end (bit_end)
  );

  always_comb begin
    state_d     = state_q;
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    hold_last_d = hold_last_q;
    sh_d        = sh_q;
    cur_last_d  = cur_last_q;
    par_d       = par_q;
    bit_cnt_d   = bit_cnt_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    load        = 1'b0;
    boundary    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          state_d = ST_SOF;
          load    = 1'b1;
        end
      end
      ST_SOF: begin
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          sh_d = sh_q >> 1;
          if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
            bit_cnt_d = '0;
            if (PARITY_EN) state_d = ST_PARITY;
            else           boundary = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) boundary = 1'b1;
      end
      ST_EOF: begin
        if (bit_end) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Word boundary: finish, chain the held word, or close out an underrun.
    if (boundary) begin
      if (cur_last_q) begin
        state_d = ST_EOF;
      end else if (hold_full_q) begin
        state_d = ST_DATA;
        load    = 1'b1;
      end else begin
        state_d = ST_EOF;
        err_d   = 1'b1;
      end
    end

    if (load) begin
      sh_d       = hold_data_q;
      cur_last_d = hold_last_q;
      par_d      = ~(^hold_data_q);
      bit_cnt_d  = '0;
    end

    if (accept) begin
      hold_full_d = 1'b1;
      hold_data_d = in_data;
      hold_last_d = in_last;
    end else if (load) begin
      hold_full_d = 1'b0;
    end

    case (state_q)
      ST_SOF:    pat = PAT_ONE;
      ST_DATA:   pat = sh_q[0] ? PAT_ONE : PAT_ZERO;
      ST_PARITY: pat = par_q ? PAT_ONE : PAT_ZERO;
      default:   pat = PAT_NONE;
    endcase
    data_d = sub & (half ? pat[0] : pat[1]);

    if (!in_enable) begin
      state_d     = ST_IDLE;
      hold_full_d = 1'b0;
      data_d      = 1'b0;
      done_d      = 1'b0;
      err_d       = busy;
    end
  end

  always_ff @(posedge clk or posedge in_rst) begin
    if (in_rst) begin
      state_q     <= ST_IDLE;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      hold_last_q <= 1'b0;
      sh_q        <= '0;
      cur_last_q  <= 1'b0;
      par_q       <= 1'b0;
      bit_cnt_q   <= '0;
      data_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      hold_last_q <= hold_last_d;
      sh_q        <= sh_d;
      cur_last_q  <= cur_last_d;
      par_q       <= par_d;
      bit_cnt_q   <= bit_cnt_d;
      data_q      <= data_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign out_data = data_q;
  assign out_busy = busy;
  assign out_done = done_q;
  assign out_err  = err_q;

endmodule

// File: tb/tb_man_frame_tx.sv
// Directed bench for man_frame_tx: default build plus a HALF_ETU=4, DATA_W=4,
// no-parity build, with expected streams derived from a symbol list.
module tb_man_frame_tx;

  logic       clk, rst;
  logic       en0, valid0, last0;
  logic [7:0] data0;
  logic       r0, d0, b0, dn0, e0;
  logic       en1, valid1, last1;
  logic [3:0] data1;
  logic       r1, d1, b1, dn1, e1;

  int n_tests = 0;
  int n_fail  = 0;
  int syms[$];  // 2=SOF, 1=one, 0=zero, 3=EOF

  man_frame_tx dut0 (
    .clk(clk), .in_rst(rst), .in_enable(en0), .in_data(data0), .in_valid(valid0),
    .in_last(last0), .out_ready(r0), .out_data(d0), .out_busy(b0), .out_done(dn0),
    .out_err(e0)
  );

  man_frame_tx #(.HALF_ETU(4), .DATA_W(4), .PARITY_EN(1'b0)) dut1 (
    .clk(clk), .in_rst(rst), .in_enable(en1), .in_data(data1), .in_valid(valid1),
    .in_last(last1), .out_ready(r1), .out_data(d1), .out_busy(b1), .out_done(dn1),
    .out_err(e1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_bit(input int n, input int h);
    int  b, p, c;
    logic one, first_half;
    b = n / (2 * h);
    p = n % (2 * h);
    c = p % h;
    first_half = (p < h);
    if (syms[b] == 3) return 1'b0;
    one = (syms[b] != 0);
    if (one != first_half) return 1'b0;
    return (c % 2 == 0);
  endfunction

  // Called at a negedge with out_ready high; returns just after the second
  // edge following acceptance, when the first SOF output sample is next.
  task automatic send0(input logic [7:0] d, input logic l);
    data0 = d; last0 = l; valid0 = 1'b1;
    @(posedge clk); #1 valid0 = 1'b0;
    chk("accept_ready_fall", r0, 1'b0);
    chk("accept_still_idle", b0, 1'b0);
    @(posedge clk); #1;
    chk("sof_busy", b0, 1'b1);
    chk("sof_ready_free", r0, 1'b1);
    @(posedge clk);
  endtask

  task automatic watch(input bit sel, input int h, input string tag, input int exp_err);
    int total, mism, busy_bad, done_at, done_n, err_at, err_n;
    logic od, ob, odn, oe;
    total = syms.size() * 2 * h;
    mism = 0; busy_bad = 0; done_at = -1; done_n = 0; err_at = -1; err_n = 0;
    for (int n = 0; n < total + 3; n++) begin
      @(negedge clk);
      od  = sel ? d1  : d0;
      ob  = sel ? b1  : b0;
      odn = sel ? dn1 : dn0;
      oe  = sel ? e1  : e0;
      if (n < total) begin
        if (od !== model_bit(n, h)) mism++;
      end else if (od !== 1'b0) mism++;
      if (n < total - 1 && ob !== 1'b1) busy_bad++;
      if (n >= total && ob !== 1'b0) busy_bad++;
      if (odn === 1'b1) begin done_n++; done_at = n; end
      if (oe === 1'b1) begin err_n++; err_at = n; end
    end
    chk({tag, "_stream"}, mism, 0);
    chk({tag, "_busy"}, busy_bad, 0);
    chk({tag, "_done_at"}, done_at, total - 1);
    chk({tag, "_done_cnt"}, done_n, 1);
    chk({tag, "_err_at"}, err_at, exp_err);
    chk({tag, "_err_cnt"}, err_n, (exp_err < 0) ? 0 : 1);
  endtask

  initial begin
    int bad;
    clk = 0; rst = 1;
    en0 = 1; valid0 = 0; data0 = '0; last0 = 0;
    en1 = 1; valid1 = 0; data1 = '0; last1 = 0;
    repeat (2) @(negedge clk);
    chk("rst_ready", r0, 1'b1);
    chk("rst_busy", b0, 1'b0);
    chk("rst_data", d0, 1'b0);
    chk("rst_done", dn0, 1'b0);
    chk("rst_err", e0, 1'b0);
    chk("rst_ready_h4", r1, 1'b1);
    rst = 0;
    @(negedge clk);

    // Single word 0xA5, last: 11 bit periods, done on the 176th clock.
    send0(8'hA5, 1'b1);
    syms = {2, 1, 0, 1, 0, 0, 1, 0, 1, 1, 3};
    watch(1'b0, 8, "a5", -1);

    // Back-to-back 0x00 then 0xFF, second offered while the first is held.
    data0 = 8'h00; last0 = 1'b0; valid0 = 1'b1;
    @(posedge clk); #1 data0 = 8'hFF; last0 = 1'b1;
    chk("b2b_not_ready", r0, 1'b0);
    @(posedge clk); #1 chk("b2b_ready_after_load", r0, 1'b1);
    @(posedge clk); #1 valid0 = 1'b0;
    chk("b2b_second_held", r0, 1'b0);
    syms = {2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 3};
    watch(1'b0, 8, "b2b", -1);

    // Underrun: 0x3C without last; err at end of its parity bit (sample 159).
    send0(8'h3C, 1'b0);
    syms = {2, 0, 0, 1, 1, 1, 1, 0, 0, 1, 3};
    watch(1'b0, 8, "underrun", 159);

    // Abort in the middle of data bit 4.
    send0(8'hA5, 1'b1);
    repeat (88) @(negedge clk);
    chk("abort_pre_busy", b0, 1'b1);
    en0 = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy", b0, 1'b0);
    chk("abort_err", e0, 1'b1);
    chk("abort_data", d0, 1'b0);
    chk("abort_ready_low", r0, 1'b0);
    @(posedge clk); #1;
    chk("abort_err_once", e0, 1'b0);
    chk("abort_data_hold", d0, 1'b0);
    chk("abort_no_done", dn0, 1'b0);
    en0 = 1'b1; #1;
    chk("abort_hold_cleared", r0, 1'b1);
    @(negedge clk);

    // Reset during SOF, then a clean frame 0x96.
    send0(8'h5A, 1'b1);
    repeat (3) @(negedge clk);
    chk("sof_mod_high", d0, 1'b1);
    rst = 1'b1; #1;
    chk("midrst_data", d0, 1'b0);
    chk("midrst_busy", b0, 1'b0);
    chk("midrst_ready", r0, 1'b1);
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (dn0 !== 1'b0 || e0 !== 1'b0 || d0 !== 1'b0) bad++;
    end
    chk("midrst_no_pulse", bad, 0);
    rst = 1'b0;
    @(negedge clk);
    send0(8'h96, 1'b1);
    syms = {2, 0, 1, 1, 0, 1, 0, 0, 1, 1, 3};
    watch(1'b0, 8, "post_rst", -1);

    // Small build: HALF_ETU=4, DATA_W=4, no parity, word 0x9 -> 48 clocks.
    data1 = 4'h9; last1 = 1'b1; valid1 = 1'b1;
    @(posedge clk); #1 valid1 = 1'b0;
    chk("h4_ready_fall", r1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    syms = {2, 1, 0, 0, 1, 3};
    watch(1'b1, 4, "h4", -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
